// File: rtl/hex7seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered display value.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module hex7seg_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  hex_nibble,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  typedef enum logic [1:0] {OFF, SHOW, GUARD} state_t;

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [15:0]      disp, shadow, disp_nxt;
  logic             pending, commit, lead_lit;
  logic [3:0]       digit_en_nxt, hex_nibble_nxt;
  logic             frame_done_nxt;

  assign wr_ready = ~pending;
  // Frame boundaries: idle, or the guard cycle that closes digit 3.
  assign commit   = pending && ((state == OFF) || (state == GUARD && idx == 2'd3));
  // Outputs are registered from next-cycle values, so they must see the value being committed now.
  assign disp_nxt = commit ? shadow : disp;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      digit_en   <= '0;
      hex_nibble <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      digit_en   <= digit_en_nxt;
      hex_nibble <= hex_nibble_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (commit) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (wr_valid && !pending) begin
      shadow  <= wr_data;
      pending <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = OFF;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt = SHOW;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            state_nxt = GUARD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + DIV_W'(1);
          end
        end
        GUARD: begin
          state_nxt = SHOW;
          idx_nxt   = idx + 2'd1;
        end
        default: begin
          state_nxt = OFF;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_lit = (idx_nxt == 2'd0) || ((disp_nxt >> {idx_nxt, 2'b00}) != 16'd0);
  end
`else
  always_comb begin
    lead_lit = 1'b1;
  end
`endif

  always_comb begin
    digit_en_nxt   = '0;
    hex_nibble_nxt = hex_nibble;
    frame_done_nxt = 1'b0;
    case (state_nxt)
      OFF:   hex_nibble_nxt = '0;
      SHOW: begin
        digit_en_nxt   = lead_lit ? (4'b0001 << idx_nxt) : 4'b0000;
        hex_nibble_nxt = disp_nxt[{idx_nxt, 2'b00} +: 4];
      end
      GUARD: frame_done_nxt = (idx_nxt == 2'd3);
      default: hex_nibble_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_hex7seg_scan_ctrl.sv
// Directed self-checking bench for hex7seg_scan_ctrl with DIV=4 (20-cycle frames).
// Leading-zero expectations follow the LEADING_ZERO_BLANK_EN build macro.
module tb_hex7seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int FRAME = 4 * (DIV + 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] MASK_0030 = 4'b0011;
  localparam logic [3:0] MASK_0000 = 4'b0001;
`else
  localparam logic [3:0] MASK_0030 = 4'b1111;
  localparam logic [3:0] MASK_0000 = 4'b1111;
`endif
  localparam logic [3:0] MASK_ALL = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  hex_nibble;
  logic [3:0]  digit_en;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  hex7seg_scan_ctrl #(.DIV(DIV), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .hex_nibble(hex_nibble), .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] de, input logic [3:0] hn,
                         input logic fd, input logic rdy);
    chk({tag, ".digit_en"},   {12'b0, digit_en},   {12'b0, de});
    chk({tag, ".hex_nibble"}, {12'b0, hex_nibble}, {12'b0, hn});
    chk({tag, ".frame_done"}, {15'b0, frame_done}, {15'b0, fd});
    chk({tag, ".wr_ready"},   {15'b0, wr_ready},   {15'b0, rdy});
  endtask

  // Checks a frame cycle by cycle from cycle 'start'; optionally offers one write at 'wr_cycle'.
  // Any pending value commits on the frame's last edge, so wr_ready is 1 at the next frame start.
  task automatic run_frame(input string tag, input logic [15:0] val, input logic [3:0] mask,
                           input int start, input int wr_cycle, input logic [15:0] wr_val,
                           input logic rdy_in);
    logic       rdy;
    logic [3:0] nib;
    logic [3:0] de;
    int         k;
    int         c;
    rdy = rdy_in;
    for (int n = start; n < FRAME; n++) begin
      k   = n / (DIV + 1);
      c   = n % (DIV + 1);
      nib = val[4*k +: 4];
      if (c < DIV) begin
        de = mask[k] ? (4'b0001 << k) : 4'b0000;
        chk_out($sformatf("%s.show%0d", tag, n), de, nib, 1'b0, rdy);
      end else begin
        chk_out($sformatf("%s.guard%0d", tag, n), 4'b0000, nib, (k == 3), rdy);
      end
      if (n == wr_cycle) begin
        wr_valid = 1'b1;
        wr_data  = wr_val;
      end
      step();
      if (n == wr_cycle) begin
        wr_valid = 1'b0;
        rdy      = 1'b0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0000;
    repeat (2) step();
    chk_out("reset", 4'b0000, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    step();

    // Write in OFF: commits the cycle after the transfer.
    wr_valid = 1'b1;
    wr_data  = 16'h1A2F;
    step();
    wr_valid = 1'b0;
    chk_out("off_pending", 4'b0000, 4'h0, 1'b0, 1'b0);
    step();
    chk_out("off_commit", 4'b0000, 4'h0, 1'b0, 1'b1);

    // Basic scan, one cycle from en to digit 0.
    en = 1'b1;
    step();
    run_frame("scan_a", 16'h1A2F, MASK_ALL, 0, -1, 16'h0, 1'b1);
    // Tear-free: writes mid-frame appear only from the next frame.
    run_frame("scan_b", 16'h1A2F, MASK_ALL, 0, 0, 16'h1234, 1'b1);
    run_frame("tear_1234", 16'h1234, MASK_ALL, 0, 6, 16'hABCD, 1'b1);
    run_frame("tear_abcd", 16'hABCD, MASK_ALL, 0, -1, 16'h0, 1'b1);

    // Back-pressure: source holds wr_valid across two values.
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    step();
    wr_data = 16'h6666;
    run_frame("bp_abcd", 16'hABCD, MASK_ALL, 1, -1, 16'h0, 1'b0);
    chk_out("bp_5555_start", 4'b0001, 4'h5, 1'b0, 1'b1);
    step();
    wr_valid = 1'b0;
    run_frame("bp_5555", 16'h5555, MASK_ALL, 1, -1, 16'h0, 1'b0);
    run_frame("bp_6666", 16'h6666, MASK_ALL, 0, -1, 16'h0, 1'b1);

    // Enable drop during digit 2.
    repeat (11) step();
    chk_out("drop_before", 4'b0100, 4'h6, 1'b0, 1'b1);
    en = 1'b0;
    step();
    chk_out("drop_off", 4'b0000, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk({"drop_no_frame_done"}, {15'b0, frame_done}, 16'h0000);
    end
    en = 1'b1;
    step();
    run_frame("reenable", 16'h6666, MASK_ALL, 0, -1, 16'h0, 1'b1);

    // Leading zeros.
    en = 1'b0;
    step();
    wr_valid = 1'b1;
    wr_data  = 16'h0030;
    step();
    wr_valid = 1'b0;
    step();
    en = 1'b1;
    step();
    run_frame("lz_0030", 16'h0030, MASK_0030, 0, 0, 16'h0000, 1'b1);
    run_frame("lz_0000", 16'h0000, MASK_0000, 0, -1, 16'h0, 1'b1);

    // Asynchronous reset mid-SHOW with a pending write: pending value is lost.
    run_frame("pre_rst", 16'h0000, MASK_0000, 0, 0, 16'h1111, 1'b1);
    step();
    chk_out("rst_prep", 4'b0001, 4'h1, 1'b0, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 16'h2222;
    step();
    wr_valid = 1'b0;
    chk({"rst_pending"}, {15'b0, wr_ready}, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_async", 4'b0000, 4'h0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk_out("rst_restart", 4'b0001, 4'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
